// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: issues in-order imem requests, queues returned words with their PCs for decode.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNT_W = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_pc,
   output logic        o_pc_enable,
   input  logic        i_flush,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_id_valid,
   output logic [31:0] o_id_instr,
   output logic [31:0] o_id_pc,
   input  logic        i_id_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] o_perf_stall_cnt,
   output logic [31:0] o_perf_flush_cnt
`endif
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OW = CNT_W + 1;

   typedef enum logic {S_FETCH = 1'b0, S_DRAIN = 1'b1} state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_drop;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_pq_rd;
   logic [AW-1:0]    r_pq_wr;
   logic [31:0]      r_fifo_instr [DEPTH];
   logic [31:0]      r_fifo_pc    [DEPTH];
   logic [31:0]      r_pq         [DEPTH];

   logic [OW-1:0]    w_occupancy;
   logic             w_issue;
   logic             w_accept;
   logic             w_valid;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_out_next;
   logic [CNT_W-1:0] w_drop_next;

   // Buffered entries plus in-flight requests bound the issue window.
   assign w_occupancy = OW'(r_count) + OW'(r_outstanding);
   assign w_issue     = (r_state == S_FETCH) && !i_flush && !i_rst && (w_occupancy < OW'(DEPTH));
   assign w_accept    = w_issue && i_imem_gnt;
   assign w_valid     = (r_count != '0) && !i_rst;
   assign w_push      = i_imem_rvalid && (r_drop == '0) && !i_flush;
   assign w_pop       = w_valid && i_id_ready && !i_flush;
   assign w_out_next  = r_outstanding + CNT_W'(w_accept) - CNT_W'(i_imem_rvalid);

   // On a redirect every request still in flight becomes stale.
   assign w_drop_next = i_flush ? w_out_next :
                        (i_imem_rvalid && (r_drop != '0)) ? (r_drop - CNT_W'(1)) : r_drop;

   assign o_imem_req  = w_issue;
   assign o_imem_addr = w_issue ? i_pc : 32'h0;
   assign o_pc_enable = !i_rst && (w_accept || i_flush);
   assign o_id_valid  = w_valid;
   assign o_id_instr  = w_valid ? r_fifo_instr[r_rd_ptr] : 32'h0;
   assign o_id_pc     = w_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_FETCH;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_pq_rd       <= '0;
         r_pq_wr       <= '0;
      end else begin
         r_outstanding <= w_out_next;
         r_drop        <= w_drop_next;
         if (w_accept) r_pq_wr <= r_pq_wr + AW'(1);
         if (i_imem_rvalid) r_pq_rd <= r_pq_rd + AW'(1);
         if (i_flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_state  <= (w_drop_next != '0) ? S_DRAIN : S_FETCH;
         end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if ((r_state == S_DRAIN) && (w_drop_next == '0)) r_state <= S_FETCH;
         end
      end
   end

   // Storage arrays carry no reset; occupancy counters qualify them.
   always_ff @(posedge i_clk) begin
      if (w_accept) r_pq[r_pq_wr] <= i_pc;
      if (w_push) begin
         r_fifo_instr[r_wr_ptr] <= i_imem_rdata;
         r_fifo_pc[r_wr_ptr]    <= r_pq[r_pq_rd];
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_perf_stall_cnt <= '0;
         o_perf_flush_cnt <= '0;
      end else begin
         if (i_id_ready && !w_valid && (o_perf_stall_cnt != 32'hFFFF_FFFF))
            o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
         if (i_flush && (o_perf_flush_cnt != 32'hFFFF_FFFF))
            o_perf_flush_cnt <= o_perf_flush_cnt + 32'd1;
      end
   end
`endif

   a_rvalid_needs_outstanding: assert property (
      @(posedge i_clk) disable iff (i_rst) i_imem_rvalid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: drives a PC register and an in-order memory around the DUT.
module tb_fetch_buffer;

   logic        i_clk;
   logic        i_rst;
   logic [31:0] i_pc;
   logic        o_pc_enable;
   logic        i_flush;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_id_valid;
   logic [31:0] o_id_instr;
   logic [31:0] o_id_pc;
   logic        i_id_ready;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] o_perf_stall_cnt;
   logic [31:0] o_perf_flush_cnt;
`endif

   fetch_buffer #(.DEPTH(2), .CNT_W(2)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .o_pc_enable(o_pc_enable),
      .i_flush(i_flush), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
      .o_id_valid(o_id_valid), .o_id_instr(o_id_instr), .o_id_pc(o_id_pc),
      .i_id_ready(i_id_ready)
`ifdef FETCH_PERF_CNT_EN
      , .o_perf_stall_cnt(o_perf_stall_cnt), .o_perf_flush_cnt(o_perf_flush_cnt)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_pass = 0;
   int n_total = 0;

   logic [31:0] pc_reg;
   logic [31:0] flush_tgt;
   logic        gnt_en, rsp_en, flush_req;
   logic [31:0] resp_q[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_instr[$];
   logic        s_req, s_pcen, s_valid;
   logic [31:0] s_addr, s_instr, s_pc;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return {pc[23:0], 8'h13};
   endfunction

   // One clock: drive inputs, sample at the falling edge, then advance the environment.
   task automatic tick();
      logic [31:0] tmp;
      i_pc          = pc_reg;
      i_imem_gnt    = gnt_en;
      i_flush       = flush_req;
      i_imem_rvalid = rsp_en && (resp_q.size() != 0) && !i_rst;
      i_imem_rdata  = i_imem_rvalid ? instr_of(resp_q[0]) : 32'h0;
      #4;
      s_req = o_imem_req; s_pcen = o_pc_enable; s_valid = o_id_valid;
      s_addr = o_imem_addr; s_instr = o_id_instr; s_pc = o_id_pc;
      @(posedge i_clk);
      if (!i_rst) begin
         if (s_req && i_imem_gnt) resp_q.push_back(pc_reg);
         if (i_imem_rvalid) tmp = resp_q.pop_front();
         if (s_valid && i_id_ready && !i_flush) begin
            got_pc.push_back(s_pc);
            got_instr.push_back(s_instr);
         end
         if (s_pcen) pc_reg = i_flush ? flush_tgt : pc_reg + 32'd4;
      end
      #1;
   endtask

   task automatic do_reset(input logic [31:0] pc0);
      i_rst = 1'b1; flush_req = 1'b0;
      resp_q.delete(); got_pc.delete(); got_instr.delete();
      pc_reg = pc0;
      tick(); tick();
      i_rst = 1'b0;
   endtask

   task automatic wait_got(input int n);
      for (int k = 0; k < 40 && got_pc.size() < n; k++) tick();
      n_total++;
      if (got_pc.size() < n) $display("FAIL wait_got: got %0d entries want %0d", got_pc.size(), n);
      else n_pass++;
   endtask

   task automatic test_reset();
      gnt_en = 1'b1; rsp_en = 1'b1; i_id_ready = 1'b1; pc_reg = 32'h0;
      i_rst = 1'b1; flush_req = 1'b0;
      tick(); tick();
      n_total++; if (s_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", s_req); else n_pass++;
      n_total++; if (s_pcen !== 1'b0) $display("FAIL reset_pcen: got %0b want 0", s_pcen); else n_pass++;
      n_total++; if (s_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", s_valid); else n_pass++;
      n_total++; if (s_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", s_instr); else n_pass++;
      n_total++; if (s_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", s_pc); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_total++; if (o_perf_stall_cnt !== 32'h0) $display("FAIL reset_stall_cnt: got %0d want 0", o_perf_stall_cnt); else n_pass++;
      n_total++; if (o_perf_flush_cnt !== 32'h0) $display("FAIL reset_flush_cnt: got %0d want 0", o_perf_flush_cnt); else n_pass++;
`endif
      i_rst = 1'b0;
   endtask

   task automatic test_stream();
      int first_req, first_valid;
      do_reset(32'h0);
      gnt_en = 1'b1; rsp_en = 1'b1; i_id_ready = 1'b1;
      first_req = -1; first_valid = -1;
      for (int k = 0; k < 40 && got_pc.size() < 4; k++) begin
         tick();
         if (first_req < 0 && s_req) first_req = k;
         if (first_valid < 0 && s_valid) first_valid = k;
      end
      n_total++;
      if (first_valid - first_req !== 2) $display("FAIL stream_latency: got %0d want 2", first_valid - first_req);
      else n_pass++;
      n_total++;
      if (got_pc.size() < 4) $display("FAIL stream_count: got %0d want 4", got_pc.size());
      else n_pass++;
      for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
         n_total++;
         if (got_pc[i] !== 32'(4 * i)) $display("FAIL stream_pc%0d: got %h want %h", i, got_pc[i], 32'(4 * i));
         else n_pass++;
         n_total++;
         if (got_instr[i] !== instr_of(32'(4 * i))) $display("FAIL stream_instr%0d: got %h want %h", i, got_instr[i], instr_of(32'(4 * i)));
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      int nacc;
      do_reset(32'h0);
      gnt_en = 1'b1; rsp_en = 1'b1; i_id_ready = 1'b0; nacc = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (s_req && i_imem_gnt) nacc++;
      end
      n_total++; if (nacc !== 2) $display("FAIL bp_requests: got %0d want 2", nacc); else n_pass++;
      n_total++; if (s_pcen !== 1'b0) $display("FAIL bp_pcen: got %0b want 0", s_pcen); else n_pass++;
      n_total++; if (s_valid !== 1'b1) $display("FAIL bp_valid: got %0b want 1", s_valid); else n_pass++;
      n_total++; if (s_pc !== 32'h0) $display("FAIL bp_head_pc: got %h want 0", s_pc); else n_pass++;
      n_total++; if (s_instr !== 32'h0000_0013) $display("FAIL bp_head_instr: got %h want 00000013", s_instr); else n_pass++;
      i_id_ready = 1'b1;
      wait_got(2);
      if (got_pc.size() >= 2) begin
         n_total++; if (got_pc[0] !== 32'h0) $display("FAIL bp_drain0: got %h want 0", got_pc[0]); else n_pass++;
         n_total++; if (got_pc[1] !== 32'h4) $display("FAIL bp_drain1: got %h want 4", got_pc[1]); else n_pass++;
         n_total++; if (got_instr[1] !== 32'h0000_0413) $display("FAIL bp_drain1_instr: got %h want 00000413", got_instr[1]); else n_pass++;
      end
   endtask

   task automatic test_gnt_stall();
      int bad;
      do_reset(32'h20);
      gnt_en = 1'b0; rsp_en = 1'b1; i_id_ready = 1'b1; bad = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (s_req !== 1'b1 || s_addr !== 32'h20 || s_pcen !== 1'b0) bad++;
      end
      n_total++; if (bad !== 0) $display("FAIL gnt_stall_hold: got %0d bad cycles want 0", bad); else n_pass++;
      n_total++; if (s_valid !== 1'b0) $display("FAIL gnt_stall_valid: got %0b want 0", s_valid); else n_pass++;
      gnt_en = 1'b1;
      tick();
      n_total++; if (s_pcen !== 1'b1) $display("FAIL gnt_release_pcen: got %0b want 1", s_pcen); else n_pass++;
      wait_got(1);
      if (got_pc.size() >= 1) begin
         n_total++; if (got_pc[0] !== 32'h20) $display("FAIL gnt_first_pc: got %h want 20", got_pc[0]); else n_pass++;
      end
   endtask

   task automatic test_flush_drain();
      int saw_valid;
      do_reset(32'h8);
      gnt_en = 1'b1; rsp_en = 1'b0; i_id_ready = 1'b1; saw_valid = 0;
      tick(); tick(); tick();
      n_total++; if (s_req !== 1'b0) $display("FAIL fd_full_req: got %0b want 0", s_req); else n_pass++;
      flush_tgt = 32'h100; flush_req = 1'b1;
      tick();
      n_total++; if (s_pcen !== 1'b1) $display("FAIL fd_flush_pcen: got %0b want 1", s_pcen); else n_pass++;
      n_total++; if (s_req !== 1'b0) $display("FAIL fd_flush_req: got %0b want 0", s_req); else n_pass++;
      flush_req = 1'b0; rsp_en = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         if (s_valid) saw_valid++;
         n_total++; if (s_req !== 1'b0) $display("FAIL fd_drain_req%0d: got %0b want 0", k, s_req); else n_pass++;
      end
      tick();
      if (s_valid) saw_valid++;
      n_total++; if (s_req !== 1'b1) $display("FAIL fd_resume_req: got %0b want 1", s_req); else n_pass++;
      n_total++; if (s_addr !== 32'h100) $display("FAIL fd_resume_addr: got %h want 100", s_addr); else n_pass++;
      n_total++; if (saw_valid !== 0) $display("FAIL fd_stale_valid: got %0d want 0", saw_valid); else n_pass++;
      wait_got(1);
      if (got_pc.size() >= 1) begin
         n_total++; if (got_pc[0] !== 32'h100) $display("FAIL fd_first_pc: got %h want 100", got_pc[0]); else n_pass++;
         n_total++; if (got_instr[0] !== 32'h0001_0013) $display("FAIL fd_first_instr: got %h want 00010013", got_instr[0]); else n_pass++;
      end
   endtask

   task automatic test_flush_rvalid();
      do_reset(32'h0);
      gnt_en = 1'b1; rsp_en = 1'b1; i_id_ready = 1'b0;
      tick(); tick();
      flush_tgt = 32'h200; flush_req = 1'b1;
      tick();
      n_total++; if (s_pc !== 32'h0 || s_valid !== 1'b1) $display("FAIL fr_head: got v=%0b pc=%h want v=1 pc=0", s_valid, s_pc); else n_pass++;
      n_total++; if (s_req !== 1'b0) $display("FAIL fr_flush_req: got %0b want 0", s_req); else n_pass++;
      flush_req = 1'b0; i_id_ready = 1'b1;
      tick();
      n_total++; if (s_valid !== 1'b0) $display("FAIL fr_post_valid: got %0b want 0", s_valid); else n_pass++;
      n_total++; if (s_req !== 1'b1 || s_addr !== 32'h200) $display("FAIL fr_post_req: got req=%0b addr=%h want req=1 addr=200", s_req, s_addr); else n_pass++;
      wait_got(1);
      if (got_pc.size() >= 1) begin
         n_total++; if (got_pc[0] !== 32'h200) $display("FAIL fr_first_pc: got %h want 200", got_pc[0]); else n_pass++;
      end
   endtask

   task automatic test_reset_midop();
      do_reset(32'h0);
      gnt_en = 1'b1; rsp_en = 1'b1; i_id_ready = 1'b0;
      tick(); tick();
      i_rst = 1'b1;
      tick(); tick();
      n_total++; if ({s_req, s_pcen, s_valid} !== 3'b000) $display("FAIL rm_ctrl: got %b want 000", {s_req, s_pcen, s_valid}); else n_pass++;
      n_total++; if (s_instr !== 32'h0 || s_pc !== 32'h0 || s_addr !== 32'h0) $display("FAIL rm_data: got instr=%h pc=%h addr=%h want 0", s_instr, s_pc, s_addr); else n_pass++;
`ifdef FETCH_PERF_CNT_EN
      n_total++; if (o_perf_stall_cnt !== 32'h0 || o_perf_flush_cnt !== 32'h0) $display("FAIL rm_perf: got %0d/%0d want 0/0", o_perf_stall_cnt, o_perf_flush_cnt); else n_pass++;
`endif
      resp_q.delete(); got_pc.delete(); got_instr.delete();
      pc_reg = 32'h40; i_rst = 1'b0; i_id_ready = 1'b1;
      tick();
      n_total++; if (s_valid !== 1'b0) $display("FAIL rm_valid: got %0b want 0", s_valid); else n_pass++;
      n_total++; if (s_req !== 1'b1 || s_addr !== 32'h40) $display("FAIL rm_req: got req=%0b addr=%h want req=1 addr=40", s_req, s_addr); else n_pass++;
      wait_got(1);
      if (got_pc.size() >= 1) begin
         n_total++; if (got_pc[0] !== 32'h40) $display("FAIL rm_first_pc: got %h want 40", got_pc[0]); else n_pass++;
      end
   endtask

   initial begin
      i_rst = 1'b1; i_flush = 1'b0; i_pc = 32'h0; i_imem_gnt = 1'b0;
      i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0; i_id_ready = 1'b0;
      flush_req = 1'b0; flush_tgt = 32'h0; gnt_en = 1'b0; rsp_en = 1'b0; pc_reg = 32'h0;
      @(posedge i_clk); #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_gnt_stall();
      test_flush_drain();
      test_flush_rvalid();
      test_reset_midop();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
